// File: rtl/hv_binarize.sv
// Majority-threshold binarizer: turns a stream of per-dimension bundle counts
// into packed OW-bit hypervector words, with ties broken to 0 or by a 16-bit LFSR.
`timescale 1ns/1ps
module hv_binarize #(
  parameter int unsigned DW       = 8,
  parameter int unsigned OW       = 32,
  parameter int unsigned NCNT     = 1024,
  parameter int unsigned TIE_MODE = 1,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] n_items,
  input  logic          cnt_valid,
  output logic          cnt_ready,
  input  logic [DW-1:0] cnt_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_word,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  localparam int unsigned BW = $clog2(OW);
  localparam int unsigned CW = $clog2(NCNT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] n_items_q, n_items_d;
  logic [OW-1:0] pack_q, pack_d;
  logic [OW-1:0] out_word_q, out_word_d;
  logic [BW-1:0] bit_idx_q, bit_idx_d;
  logic [CW-1:0] dim_q, dim_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          done_q, done_d;

  logic          start_ok, cnt_fire, out_fire;
  logic          last_dim, word_end, maj_bit, lfsr_fb;
  logic [DW:0]   twice_cnt, n_ext;

  // A start coinciding with the done pulse is dropped, not just one during busy.
  assign start_ok = (state_q == S_IDLE) && start && !done_q;
  assign cnt_fire = cnt_valid && cnt_ready;
  assign out_fire = out_valid_q && out_ready;
  assign last_dim = (dim_q == CW'(NCNT - 1));
  assign word_end = (bit_idx_q == BW'(OW - 1));
  assign lfsr_fb  = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      n_items_q   <= '0;
      pack_q      <= '0;
      out_word_q  <= '0;
      bit_idx_q   <= '0;
      dim_q       <= '0;
      lfsr_q      <= SEED;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_items_q   <= n_items_d;
      pack_q      <= pack_d;
      out_word_q  <= out_word_d;
      bit_idx_q   <= bit_idx_d;
      dim_q       <= dim_d;
      lfsr_q      <= lfsr_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_ok) state_d = S_RUN;
      S_RUN:   if (cnt_fire && last_dim) state_d = S_DRAIN;
      S_DRAIN: if (out_fire && out_last_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_ready = (state_q == S_RUN) && (!out_valid_q || out_ready);
    busy      = (state_q != S_IDLE);
    done_d    = (state_q == S_DRAIN) && out_fire && out_last_q;
  end

  // Doubling the count in DW+1 bits compares against n_items without overflow.
  always_comb begin
    twice_cnt = {cnt_data, 1'b0};
    n_ext     = {1'b0, n_items_q};
    maj_bit   = 1'b0;
    if (twice_cnt > n_ext) begin
      maj_bit = 1'b1;
    end else if ((twice_cnt == n_ext) && (TIE_MODE != 0)) begin
      maj_bit = lfsr_q[0];
    end
  end

  always_comb begin
    n_items_d   = n_items_q;
    pack_d      = pack_q;
    out_word_d  = out_word_q;
    bit_idx_d   = bit_idx_q;
    dim_d       = dim_q;
    lfsr_d      = lfsr_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    if (out_fire) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    if (start_ok) begin
      n_items_d = n_items;
      pack_d    = '0;
      bit_idx_d = '0;
      dim_d     = '0;
      lfsr_d    = SEED;
    end

    if (cnt_fire) begin
      pack_d[bit_idx_q] = maj_bit;
      lfsr_d            = {lfsr_fb, lfsr_q[15:1]};
      dim_d             = dim_q + CW'(1);
      bit_idx_d         = bit_idx_q + BW'(1);
      // A completing word overrides the drop above, keeping back-to-back words bubble-free.
      if (word_end) begin
        out_word_d  = pack_d;
        out_valid_d = 1'b1;
        out_last_d  = last_dim;
        pack_d      = '0;
        bit_idx_d   = '0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign out_last  = out_last_q;
  assign done      = done_q;

endmodule

// File: tb/tb_hv_binarize.sv
// Directed bench for hv_binarize (DW=8, OW=8, NCNT=16); two instances share
// stimulus, one with tie-to-zero and one with LFSR tie-break.
`timescale 1ns/1ps
module tb_hv_binarize;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] n_items = '0;
  logic       cnt_valid = 1'b0;
  logic [7:0] cnt_data = '0;
  logic       out_ready = 1'b1;

  logic       cnt_ready0, out_valid0, out_last0, busy0, done0;
  logic [7:0] out_word0;
  logic       cnt_ready1, out_valid1, out_last1, busy1, done1;
  logic [7:0] out_word1;

  hv_binarize #(.DW(8), .OW(8), .NCNT(16), .TIE_MODE(0), .SEED(16'hACE1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .n_items(n_items),
    .cnt_valid(cnt_valid), .cnt_ready(cnt_ready0), .cnt_data(cnt_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_word(out_word0),
    .out_last(out_last0), .busy(busy0), .done(done0));

  hv_binarize #(.DW(8), .OW(8), .NCNT(16), .TIE_MODE(1), .SEED(16'hACE1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .n_items(n_items),
    .cnt_valid(cnt_valid), .cnt_ready(cnt_ready1), .cnt_data(cnt_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_word(out_word1),
    .out_last(out_last1), .busy(busy1), .done(done1));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]        n;
    logic [15:0][7:0]  cnt;
    logic [7:0]        w0;   // expected words with ties resolved to 0
    logic [7:0]        w1;
    logic              stall;
    logic              poke;
    logic              done_start;
  } vec_t;

  vec_t       tv[5];
  int         n_chk = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         last_acc_cyc = 0;
  logic [7:0] words0[$];
  logic       lasts0[$];
  logic [7:0] words1[$];

  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(negedge clk);
    #3;
    if (rst_n && out_valid0 && out_ready) begin
      words0.push_back(out_word0);
      lasts0.push_back(out_last0);
      if (out_last0) last_acc_cyc = cyc;
    end
    if (rst_n && out_valid1 && out_ready) words1.push_back(out_word1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [15:0] model_tie(input logic [7:0] n, input logic [15:0][7:0] c);
    logic [15:0] l;
    logic [15:0] bits;
    logic [8:0]  tw;
    l    = 16'hACE1;
    bits = '0;
    for (int k = 0; k < 16; k++) begin
      tw = {c[k], 1'b0};
      if (tw > {1'b0, n})       bits[k] = 1'b1;
      else if (tw == {1'b0, n}) bits[k] = l[0];
      else                      bits[k] = 1'b0;
      l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    end
    return bits;
  endfunction

  task automatic chk_reset(input string nm);
    chk({nm, "_out_valid"}, {31'd0, out_valid1}, 0);
    chk({nm, "_out_word"},  {24'd0, out_word1}, 0);
    chk({nm, "_out_last"},  {31'd0, out_last1}, 0);
    chk({nm, "_cnt_ready"}, {31'd0, cnt_ready1}, 0);
    chk({nm, "_busy"},      {31'd0, busy1}, 0);
    chk({nm, "_done"},      {31'd0, done1}, 0);
    chk({nm, "_dut0_valid"}, {31'd0, out_valid0}, 0);
  endtask

  task automatic do_start(input logic [7:0] n, input string nm);
    @(negedge clk);
    start   = 1'b1;
    n_items = n;
    @(negedge clk);
    start = 1'b0;
    #4;
    chk({nm, "_busy_after_start"}, {31'd0, busy1}, 1);
  endtask

  task automatic feed(input logic [15:0][7:0] c, input int nf, input logic stall,
                      input logic poke, input string nm);
    int         i = 0;
    int         guard = 0;
    int         scnt = 0;
    logic       stalled = 1'b0;
    logic       poked = 1'b0;
    logic [7:0] hold = '0;
    while (i < nf && guard < 300) begin
      @(negedge clk);
      guard++;
      #1;
      start = 1'b0;
      if (stall && !stalled && out_valid1) begin
        stalled   = 1'b1;
        hold      = out_word1;
        out_ready = 1'b0;
        scnt      = 10;
      end
      #1;
      if (scnt > 0) begin
        cnt_valid = 1'b0;
        chk({nm, "_stall_cnt_ready"}, {31'd0, cnt_ready1}, 0);
        chk({nm, "_stall_out_valid"}, {31'd0, out_valid1}, 1);
        chk({nm, "_stall_out_word"},  {24'd0, out_word1}, {24'd0, hold});
        scnt--;
        if (scnt == 0) out_ready = 1'b1;
      end else begin
        cnt_valid = 1'b1;
        cnt_data  = c[i];
        if (poke && i == 8 && !poked) begin
          start   = 1'b1;
          n_items = 8'd0;
          poked   = 1'b1;
        end
        if (cnt_ready1) i++;
      end
    end
    chk({nm, "_feed_count"}, i, nf);
    @(negedge clk);
    cnt_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic wait_done(input logic ds, input string nm);
    logic found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      #4;
      if (done1) begin
        found = 1'b1;
        chk({nm, "_done_cycle"}, cyc, last_acc_cyc + 1);
        chk({nm, "_busy_at_done"}, {31'd0, busy1}, 0);
        chk({nm, "_done_dut0"}, {31'd0, done0}, 1);
        if (ds) begin
          start   = 1'b1;
          n_items = 8'd5;
        end
      end
    end
    chk({nm, "_done_seen"}, {31'd0, found}, 1);
    if (found) begin
      @(negedge clk);
      start = 1'b0;
      #4;
      chk({nm, "_done_single"}, {31'd0, done1}, 0);
      chk({nm, "_idle_after_done"}, {31'd0, busy1}, 0);
    end
  endtask

  task automatic run_pass(input vec_t t, input string nm);
    int          b0 = words0.size();
    int          b1 = words1.size();
    logic [15:0] m;
    m = model_tie(t.n, t.cnt);
    do_start(t.n, nm);
    feed(t.cnt, 16, t.stall, t.poke, nm);
    wait_done(t.done_start, nm);
    chk({nm, "_nwords0"}, words0.size() - b0, 2);
    chk({nm, "_nwords1"}, words1.size() - b1, 2);
    if (words0.size() >= b0 + 2) begin
      chk({nm, "_tz_w0"}, {24'd0, words0[b0]},     {24'd0, t.w0});
      chk({nm, "_tz_w1"}, {24'd0, words0[b0 + 1]}, {24'd0, t.w1});
      chk({nm, "_last0"}, {31'd0, lasts0[b0]},     0);
      chk({nm, "_last1"}, {31'd0, lasts0[b0 + 1]}, 1);
    end
    if (words1.size() >= b1 + 2) begin
      chk({nm, "_lfsr_w0"}, {24'd0, words1[b1]},     {24'd0, m[7:0]});
      chk({nm, "_lfsr_w1"}, {24'd0, words1[b1 + 1]}, {24'd0, m[15:8]});
    end
  endtask

  initial begin
    int s0[16] = '{3, 2, 5, 0, 4, 1, 3, 2, 0, 0, 0, 0, 5, 5, 5, 5};
    for (int k = 0; k < 16; k++) begin
      tv[0].cnt[k] = 8'(s0[k]);
      tv[1].cnt[k] = 8'd2;
      tv[2].cnt[k] = (k % 2 == 0) ? 8'd128 : 8'd127;
      tv[3].cnt[k] = (k % 2 == 0) ? 8'd0 : 8'd1;
      tv[4].cnt[k] = 8'd2;
    end
    tv[0].n = 8'd5;   tv[0].w0 = 8'h55; tv[0].w1 = 8'hF0;
    tv[1].n = 8'd4;   tv[1].w0 = 8'h00; tv[1].w1 = 8'h00;
    tv[2].n = 8'd255; tv[2].w0 = 8'h55; tv[2].w1 = 8'h55;
    tv[3].n = 8'd0;   tv[3].w0 = 8'hAA; tv[3].w1 = 8'hAA;
    tv[4].n = 8'd4;   tv[4].w0 = 8'h00; tv[4].w1 = 8'h00;
    for (int v = 0; v < 5; v++) begin
      tv[v].stall      = (v == 2);
      tv[v].poke       = (v == 1);
      tv[v].done_start = (v == 0);
    end

    repeat (3) @(negedge clk);
    #4;
    chk_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) run_pass(tv[v], $sformatf("v%0d", v));

    do_start(8'd5, "abort");
    feed(tv[0].cnt, 5, 1'b0, 1'b0, "abort");
    #2;
    rst_n = 1'b0;
    #2;
    chk_reset("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #4;
    chk("abort_no_done", {31'd0, done1}, 0);
    chk("abort_idle", {31'd0, busy1}, 0);
    run_pass(tv[0], "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
